// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures register-file and data-memory writes into a circular FIFO and drains
// them over a valid/ready stream. Optional per-entry cycle stamps: define TRACE_TIMESTAMP_EN.
module wb_trace_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reg_write_sig,
    input  logic [4:0]             reg_num,
    input  logic [DATA_W-1:0]      reg_data,
    input  logic                   wr,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic                   trace_kind,
    output logic [ADDR_W-1:0]      trace_tag,
    output logic [DATA_W-1:0]      trace_data,
    output logic [15:0]            trace_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    input  logic                   clr_ovf
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 1 + ADDR_W + DATA_W;
    localparam logic [CW:0] DepthF = (CW+1)'(DEPTH);

    logic [EW-1:0] entry_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr1, rd_ptr_d;
    logic [CW-1:0] count_d;
    logic [CW:0]   free;
    logic          pop, r_ev, m_ev, push0, push1;
    logic [1:0]    n_drop;
    logic [EW-1:0] reg_entry, mem_entry, e0, head_d;
    logic          ovf_d;
    logic [8:0]    drop_sum;
    logic [7:0]    drop_d;

    always_comb begin
        pop       = trace_valid && trace_ready;
        r_ev      = reg_write_sig && (reg_num != 5'd0);
        m_ev      = wr;
        free      = DepthF - {1'b0, count} + (CW+1)'(pop);
        reg_entry = {1'b0, ADDR_W'(reg_num), reg_data};
        mem_entry = {1'b1, addr, wr_data};
        e0        = r_ev ? reg_entry : mem_entry;
        push0     = 1'b0;
        push1     = 1'b0;
        n_drop    = 2'd0;
        // Register write always takes the first free slot; memory write follows it.
        if (r_ev && m_ev) begin
            if (free >= (CW+1)'(2)) begin
                push0 = 1'b1;
                push1 = 1'b1;
            end else if (free == (CW+1)'(1)) begin
                push0  = 1'b1;
                n_drop = 2'd1;
            end else begin
                n_drop = 2'd2;
            end
        end else if (r_ev || m_ev) begin
            if (free != '0) push0 = 1'b1;
            else            n_drop = 2'd1;
        end
        wr_ptr1  = wr_ptr + PW'(1);
        rd_ptr_d = rd_ptr + PW'(pop);
        count_d  = count + CW'(push0) + CW'(push1) - CW'(pop);
    end

    // Next head, bypassing storage when the new head is being written this cycle.
    always_comb begin
        if (count_d == '0)                          head_d = '0;
        else if (push0 && (rd_ptr_d == wr_ptr))     head_d = e0;
        else if (push1 && (rd_ptr_d == wr_ptr1))    head_d = mem_entry;
        else                                        head_d = entry_mem[rd_ptr_d];
    end

    always_comb begin
        ovf_d    = (clr_ovf ? 1'b0 : overflow) | (n_drop != 2'd0);
        drop_sum = {1'b0, (clr_ovf ? 8'd0 : drop_cnt)} + 9'(n_drop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            trace_valid <= 1'b0;
            trace_kind  <= 1'b0;
            trace_tag   <= '0;
            trace_data  <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr      <= rd_ptr_d;
            count       <= count_d;
            trace_valid <= (count_d != '0);
            {trace_kind, trace_tag, trace_data} <= head_d;
            overflow    <= ovf_d;
            drop_cnt    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) entry_mem[wr_ptr]  <= e0;
        if (push1) entry_mem[wr_ptr1] <= mem_entry;
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [DEPTH];
    logic [15:0] head_ts_d;

    always_comb begin
        if (count_d == '0)                          head_ts_d = 16'h0;
        else if (push0 && (rd_ptr_d == wr_ptr))     head_ts_d = ts_q;
        else if (push1 && (rd_ptr_d == wr_ptr1))    head_ts_d = ts_q;
        else                                        head_ts_d = ts_mem[rd_ptr_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= 16'h0;
            trace_ts <= 16'h0;
        end else begin
            ts_q     <= ts_q + 16'h1;
            trace_ts <= head_ts_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) ts_mem[wr_ptr]  <= ts_q;
        if (push1) ts_mem[wr_ptr1] <= ts_q;
    end
`else
    assign trace_ts = 16'h0;
`endif

endmodule
